// File: rtl/rr_mux_reg.sv
// Registered N:1 selector with per-channel valid/ready handshake.
// Channel choice is either an external index (mode=0) or round-robin from a rotating pointer (mode=1).
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             gany;
  logic [SEL_W-1:0] gidx;
  logic             xfer;

  // Grant search: the first hit wins, so at most one channel is granted.
  always_comb begin
    int unsigned idx;
    gany = 1'b0;
    gidx = '0;
    idx  = 0;
    if (!mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gany = 1'b1;
          gidx = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!gany && in_valid[SEL_W'(idx)]) begin
          gany = 1'b1;
          gidx = SEL_W'(idx);
        end
      end
    end
  end

  assign load     = ~valid_q | out_ready;
  assign xfer     = gany & load & ~reset;
  assign in_ready = xfer ? (CHANNELS'(1) << gidx) : '0;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = in_data[gidx*WIDTH +: WIDTH];
      chan_d  = gidx;
      valid_d = 1'b1;
      if (mode) ptr_d = (gidx == SEL_W'(CHANNELS-1)) ? '0 : gidx + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: a 4-channel instance under directed and random traffic,
// plus a 3-channel instance exercising round-robin wrap on a non-power-of-two count.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mode, out_ready;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;

  logic        reset3, mode3, out_ready3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;

  rr_mux_reg #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_mux_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset3), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit done3    = 0;

  logic [9:0] sb[$];   // {data, chan}
  bit         m_ov   = 0;
  int         m_ptr  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which channel the selection rules pick, or -1 for none.
  function automatic int model_grant(input int c, input bit m, input int s,
                                     input int p, input logic [3:0] v);
    if (!m) return (s < c && v[s]) ? s : -1;
    for (int k = 0; k < c; k++)
      if (v[(p + k) % c]) return (p + k) % c;
    return -1;
  endfunction

  task automatic cycle(input bit rst, input bit m, input logic [1:0] s,
                       input logic [3:0] v, input logic [31:0] d, input bit ordy);
    int g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    reset = rst; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    check("out_valid", out_valid, m_ov);
    g = rst ? -1 : model_grant(4, m, int'(s), m_ptr, v);
    exp_rdy = (g >= 0 && (!m_ov || ordy)) ? 4'(1 << g) : 4'b0;
    check("in_ready", in_ready, exp_rdy);
    if (exp_rdy != 0) sb.push_back({d[g*8 +: 8], 2'(g)});
    #2;
    if (rst) begin
      m_ov = 0; m_ptr = 0; sb.delete();
    end else if (exp_rdy != 0) begin
      m_ov = 1;
      if (m) m_ptr = (g + 1) % 4;
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
  endtask

  // Monitor: whatever the DUT presents must be the oldest expected word; held words must not change.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("out_data", out_data, sb[0][9:2]);
          check("out_chan", out_chan, sb[0][1:0]);
          if (out_ready && !reset) void'(sb.pop_front());
        end
      end
    end
  end

  // Main stimulus for the 4-channel instance.
  initial begin
    reset = 1; mode = 0; sel = 0; in_valid = 0; in_data = 0; out_ready = 0;
    cycle(1, 1, 0, 4'b1111, 32'h1122_3344, 1);
    cycle(1, 1, 0, 4'b1111, 32'h1122_3344, 1);
    @(posedge clk); #1;
    check("reset_out_data", out_data, 0);
    check("reset_out_chan", out_chan, 0);
    check("reset_out_valid", out_valid, 0);

    cycle(0, 0, 2, 4'b0100, 32'h00A5_0000, 1);
    cycle(0, 0, 1, 4'b0100, 32'h00A5_0000, 1);
    cycle(0, 0, 1, 4'b0100, 32'h00A5_0000, 1);

    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 4'b1111, 32'h4433_2211 + 32'(i), 1);

    cycle(0, 1, 0, 4'b1111, 32'hDEAD_BEEF, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'b1111, 32'h0102_0304, 0);
    cycle(0, 1, 0, 4'b1111, 32'h5566_7788, 1);
    cycle(0, 1, 0, 4'b0000, 32'h0, 1);

    cycle(0, 1, 0, 4'b1111, 32'h99AA_BBCC, 1);
    cycle(1, 1, 0, 4'b1111, 32'h1234_5678, 1);
    cycle(0, 1, 0, 4'b1111, 32'h8765_4321, 1);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
            4'($urandom), $urandom, ($urandom_range(0, 3) != 0));

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 4'b0000, 32'h0, 1);
    check("scoreboard_empty", sb.size(), 0);

    for (int i = 0; i < 100 && !done3; i++) @(posedge clk);
    check("dut3_done", done3, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // 3-channel instance: reach ptr=2 then show grant 2 followed by wrap to 0.
  initial begin
    logic [2:0] vtab[5];
    int p3, g3, prev3;
    vtab[0] = 3'b111; vtab[1] = 3'b111; vtab[2] = 3'b101; vtab[3] = 3'b101; vtab[4] = 3'b000;
    reset3 = 1; mode3 = 1; sel3 = 0; in_valid3 = 0; in_data3 = 24'h33_22_11; out_ready3 = 1;
    @(negedge clk); @(negedge clk);
    reset3 = 0;
    p3 = 0; prev3 = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid3 = vtab[i];
      #1;
      if (prev3 >= 0) check("ch3_out_chan", out_chan3, prev3);
      g3 = model_grant(3, 1, 0, p3, {1'b0, vtab[i]});
      check("ch3_in_ready", in_ready3, (g3 >= 0) ? 3'(1 << g3) : 3'b0);
      if (g3 >= 0) p3 = (g3 + 1) % 3;
      prev3 = g3;
    end
    done3 = 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
